// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the controller datapath: register width, instruction
// opcodes, the multiply/divide unit's op encoding and its FSM state type.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 16;

    // Instruction opcodes as seen by the controller's decode step.
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_MUL   = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_LOAD  = 3'b100;
    localparam logic [2:0] OP_STORE = 3'b101;

    // Operation select on the mul_div_unit 'op' port.
    localparam logic MD_MUL = 1'b0;
    localparam logic MD_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/mul_div_sign_adj.sv
// -----------------------------------------------------------------------------
// mul_div_sign_adj
// Conditional two's-complement negate. Used to take operand magnitudes at
// accept time (neg = operand sign) and to apply the result sign at the end of
// the calculation (neg = XOR of operand signs, or dividend sign for remainder).
//
// Ports:
//   val  in   W   value to adjust
//   neg  in   1   1 = negate, 0 = pass through
//   res  out  W   adjusted value
// -----------------------------------------------------------------------------
module mul_div_sign_adj #(
    parameter int W = 16
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Iterative signed multiply / divide engine. Magnitudes are processed with a
// shift-add multiplier or a restoring divider, one bit per clock, and the sign
// is applied when the result is registered.
//
// Ports:
//   clk          in   1       rising-edge clock
//   reset        in   1       synchronous active-high reset
//   start        in   1       request, honoured only while ready=1
//   op           in   1       0 = MUL, 1 = DIV
//   a            in   DATA_W  multiplicand / dividend (signed)
//   b            in   DATA_W  multiplier / divisor (signed)
//   result       out  DATA_W  MUL low product half / DIV quotient
//   hi           out  DATA_W  MUL high product half / DIV remainder
//   done         out  1       one-cycle pulse, outputs valid from this cycle
//   ready        out  1       unit can accept start
//   div_by_zero  out  1       DIV with b=0, valid with done
// -----------------------------------------------------------------------------
module mul_div_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ITER   = DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] hi,
    output logic              done,
    output logic              ready,
    output logic              div_by_zero
);

    // Magnitudes need one extra bit so that |most-negative| survives.
    localparam int MAG_W = DATA_W + 1;
    // Accumulator: upper MAG_W bits are partial product / partial remainder,
    // lower DATA_W bits hold the multiplier being consumed or quotient bits.
    localparam int ACC_W = 2 * DATA_W + 1;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_q, op_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic [MAG_W-1:0]  a_mag_q, a_mag_d;
    logic [MAG_W-1:0]  b_mag_q, b_mag_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic              dbz_q, dbz_d;

    // ---------------------------------------------------------------- abs(a,b)
    logic [MAG_W-1:0] a_abs, b_abs;

    mul_div_sign_adj #(.W(MAG_W)) u_abs_a (
        .val ({a[DATA_W-1], a}),
        .neg (a[DATA_W-1]),
        .res (a_abs)
    );

    mul_div_sign_adj #(.W(MAG_W)) u_abs_b (
        .val ({b[DATA_W-1], b}),
        .neg (b[DATA_W-1]),
        .res (b_abs)
    );

    // ----------------------------------------------------------- one MUL step
    // Add the multiplicand into the upper half when the current multiplier
    // bit is set, then shift the whole accumulator right by one.
    logic [MAG_W:0]   mul_sum;
    logic [ACC_W-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[ACC_W-1:DATA_W]}
                    + (acc_q[0] ? {1'b0, a_mag_q} : '0);
    assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

    // ----------------------------------------------------------- one DIV step
    // Shift the next dividend bit into the partial remainder and try the
    // subtraction; keep it (quotient bit 1) only if it did not borrow.
    logic [ACC_W-1:0] div_shift;
    logic [MAG_W:0]   div_trial;
    logic [ACC_W-1:0] div_next;

    assign div_shift = {acc_q[ACC_W-2:0], 1'b0};
    assign div_trial = {1'b0, div_shift[ACC_W-1:DATA_W]} - {1'b0, b_mag_q};
    assign div_next  = div_trial[MAG_W]
                     ? div_shift
                     : {div_trial[MAG_W-1:0], div_shift[DATA_W-1:1], 1'b1};

    // -------------------------------------------------------- sign correction
    logic [2*DATA_W-1:0] prod_adj;
    logic [DATA_W-1:0]   quot_adj, rem_adj;
    logic                div_zero;

    mul_div_sign_adj #(.W(2*DATA_W)) u_adj_prod (
        .val (acc_q[2*DATA_W-1:0]),
        .neg (sa_q ^ sb_q),
        .res (prod_adj)
    );

    mul_div_sign_adj #(.W(DATA_W)) u_adj_quot (
        .val (acc_q[DATA_W-1:0]),
        .neg (sa_q ^ sb_q),
        .res (quot_adj)
    );

    // Remainder follows the dividend, so dividing by zero returns 'a' itself.
    mul_div_sign_adj #(.W(DATA_W)) u_adj_rem (
        .val (acc_q[ACC_W-2:DATA_W]),
        .neg (sa_q),
        .res (rem_adj)
    );

    assign div_zero = (b_mag_q == '0);

    // --------------------------------------------------------------- FSM / DP
    // CALC spans ITER iteration edges plus one final cycle (cnt == ITER) in
    // which the settled accumulator is sign-corrected and registered into the
    // outputs on the edge that enters DONE.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through this
        // block leaves one unassigned, which would infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        acc_d    = acc_q;
        result_d = result_q;
        hi_d     = hi_q;
        dbz_d    = dbz_q;

        unique case (state_q)
            CALC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    if (op_q == MD_DIV) begin
                        result_d = div_zero ? '1 : quot_adj;
                        hi_d     = rem_adj;
                        dbz_d    = div_zero;
                    end else begin
                        result_d = prod_adj[DATA_W-1:0];
                        hi_d     = prod_adj[2*DATA_W-1:DATA_W];
                        dbz_d    = 1'b0;
                    end
                end else begin
                    acc_d = (op_q == MD_DIV) ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE, DONE: begin
                if (start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    op_d    = op;
                    sa_d    = a[DATA_W-1];
                    sb_d    = b[DATA_W-1];
                    a_mag_d = a_abs;
                    b_mag_d = b_abs;
                    acc_d   = {{(ACC_W-DATA_W){1'b0}},
                               (op == MD_DIV) ? a_abs[DATA_W-1:0]
                                              : b_abs[DATA_W-1:0]};
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values from
        // before this edge, independent of statement order.
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= MD_MUL;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            // NOTE: datapath registers are reset too; nothing reads them before
            // an accept, but it keeps them from ever carrying X.
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            hi_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            dbz_q    <= dbz_d;
        end
    end

    assign result      = result_q;
    assign hi          = hi_q;
    assign div_by_zero = dbz_q;
    assign done        = (state_q == DONE);
    assign ready       = (state_q != CALC);

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
// Directed test of mul_div_unit: latency, handshake, signed results, boundary
// cases, divide-by-zero, back-to-back issue and reset during calculation.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

    localparam logic OP_M = 1'b0;
    localparam logic OP_D = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [15:0] a, b;
    logic [15:0] result, hi;
    logic        done, ready, div_by_zero;

    int tests = 0;
    int fails = 0;

    mul_div_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .result      (result),
        .hi          (hi),
        .done        (done),
        .ready       (ready),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; leaves the bench on the falling edge just after
    // the accept edge with start released and the operands scrambled.
    task automatic issue(input logic o, input logic [15:0] x, input logic [15:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = ~o; a = 16'($urandom); b = 16'($urandom);
    endtask

    // Counts edges from the accept edge until done is seen (bounded), checking
    // that ready stays low meanwhile. Optionally pulses start at edge pulse_at.
    task automatic wait_done(input string tag, input int pulse_at, output int lat);
        int bad;
        bad = 0;
        lat = 0;
        if (ready !== 1'b0) bad++;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) break;
            if (ready !== 1'b0) bad++;
            if (lat == pulse_at) begin
                start = 1'b1; op = ~op; a = 16'h0001; b = 16'h0001;
            end
        end
        start = 1'b0;
        check({tag, "_ready_low"}, 32'(bad), 32'd0);
        check({tag, "_latency"}, 32'(lat), 32'd17);
    endtask

    task automatic run(input string tag, input logic o, input logic [15:0] x,
                       input logic [15:0] y, input logic [15:0] exp_r,
                       input logic [15:0] exp_h, input logic exp_z);
        int lat;
        issue(o, x, y);
        wait_done(tag, -1, lat);
        check({tag, "_result"}, 32'(result), 32'(exp_r));
        check({tag, "_hi"}, 32'(hi), 32'(exp_h));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_z));
        check({tag, "_ready_done"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int lat;
        int cnt;

        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_result", 32'(result), 32'd0);
        check("rst_hi", 32'(hi), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // -122 / 5 = -24 rem -2, then done must drop after one cycle.
        run("div_neg", OP_D, 16'hFF86, 16'h0005, 16'hFFE8, 16'hFFFE, 1'b0);
        @(negedge clk);
        check("div_neg_done_once", 32'(done), 32'd0);
        check("div_neg_hold_result", 32'(result), 32'h0000FFE8);

        // 37 * -24 = -888
        run("mul_mix", OP_M, 16'h0025, 16'hFFE8, 16'hFC88, 16'hFFFF, 1'b0);
        @(negedge clk);
        // -32768 * -1 = 32768
        run("mul_min", OP_M, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0);
        @(negedge clk);
        // -32768 / -1 wraps to 0x8000, no flag
        run("div_min", OP_D, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0);
        @(negedge clk);

        // Divide by zero, then a MUL clears the flag.
        run("div_zero", OP_D, 16'h0025, 16'h0000, 16'hFFFF, 16'h0025, 1'b1);
        @(negedge clk);
        check("div_zero_hold_flag", 32'(div_by_zero), 32'd1);
        run("mul_after_dz", OP_M, 16'h0025, 16'h000A, 16'h0172, 16'h0000, 1'b0);

        // Back-to-back: DIV issued in the done cycle of the previous MUL.
        run("b2b_div", OP_D, 16'h0025, 16'h000A, 16'h0003, 16'h0007, 1'b0);
        @(negedge clk);

        // Start pulsed mid-CALC is ignored and produces no extra done.
        issue(OP_M, 16'h0025, 16'h000A);
        wait_done("mid_start", 5, lat);
        check("mid_start_result", 32'(result), 32'h00000172);
        check("mid_start_hi", 32'(hi), 32'd0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1 || ready !== 1'b1) cnt++;
        end
        check("mid_start_no_extra", 32'(cnt), 32'd0);

        // Reset together with start at CALC cycle 8 abandons the operation.
        issue(OP_D, 16'h1234, 16'h0007);
        repeat (8) @(negedge clk);
        reset = 1'b1; start = 1'b1; op = OP_M; a = 16'h0005; b = 16'h0005;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("rst_calc_ready", 32'(ready), 32'd1);
        check("rst_calc_result", 32'(result), 32'd0);
        check("rst_calc_hi", 32'(hi), 32'd0);
        check("rst_calc_done", 32'(done), 32'd0);
        cnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        check("rst_calc_no_done", 32'(cnt), 32'd0);

        // -61 / -61 = 1 rem 0
        run("div_eq", OP_D, 16'hFFC3, 16'hFFC3, 16'h0001, 16'h0000, 1'b0);
        @(negedge clk);

        // Truncation toward zero and remainder sign.
        run("sign_nn_p", OP_D, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0);
        run("sign_p_n", OP_D, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0);
        run("sign_n_n", OP_D, 16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
